// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage LC-3b pipeline with a memory-stall watchdog.
// Define PIPE_HAZARD_STATS_EN to add the stat_* decision counters.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       imem_resp,
    input  logic       dmem_req,
    input  logic       dmem_resp,
    input  logic       br_taken,
    input  logic [2:0] id_src1,
    input  logic [2:0] id_src2,
    input  logic       id_use_src1,
    input  logic       id_use_src2,
    input  logic       ex_load,
    input  logic [2:0] ex_dest,
    output logic       adv_ifid,
    output logic       adv_idex,
    output logic       adv_exmem,
    output logic       adv_memwb,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       flush_exmem,
    output logic       pc_load,
    output logic       pc_redirect,
    output logic       target_latch,
    output logic       mem_timeout
`ifdef PIPE_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_dstall,
    output logic [CNT_W-1:0] stat_istall,
    output logic [CNT_W-1:0] stat_lduse,
    output logic [CNT_W-1:0] stat_flush
`endif
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [0:0] {
        ST_RUN        = 1'b0,
        ST_REDIR_WAIT = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [WD_W-1:0] wd_cnt_r;
    logic            mem_timeout_r;
    logic            dstall_s;
    logic            istall_s;
    logic            load_use_s;
    logic            dec_dstall_s;
    logic            dec_istall_s;
    logic            dec_lduse_s;
    logic            dec_flush_s;

    assign dstall_s    = dmem_req & ~dmem_resp;
    assign istall_s    = ~imem_resp;
    assign load_use_s  = ex_load & ((id_use_src1 & (id_src1 == ex_dest)) |
                                    (id_use_src2 & (id_src2 == ex_dest)));
    assign mem_timeout = mem_timeout_r;

    // Priority-resolved pipeline control decision and next-state selection
    always_comb begin
        adv_ifid     = 1'b0;
        adv_idex     = 1'b0;
        adv_exmem    = 1'b0;
        adv_memwb    = 1'b0;
        flush_ifid   = 1'b0;
        flush_idex   = 1'b0;
        flush_exmem  = 1'b0;
        pc_load      = 1'b0;
        pc_redirect  = 1'b0;
        target_latch = 1'b0;
        dec_dstall_s = 1'b0;
        dec_istall_s = 1'b0;
        dec_lduse_s  = 1'b0;
        dec_flush_s  = 1'b0;
        state_nxt_s  = state_r;
        if (reset) begin
            state_nxt_s = ST_RUN;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (dstall_s) begin
                        dec_dstall_s = 1'b1;
                    end else if (br_taken) begin
                        {adv_ifid, adv_idex, adv_exmem, adv_memwb} = 4'b1111;
                        {flush_ifid, flush_idex, flush_exmem}      = 3'b111;
                        pc_redirect = 1'b1;
                        dec_flush_s = 1'b1;
                        if (imem_resp) begin
                            pc_load = 1'b1;
                        end else begin
                            // Fetch still outstanding: hold the target until it returns
                            target_latch = 1'b1;
                            state_nxt_s  = ST_REDIR_WAIT;
                        end
                    end else if (load_use_s) begin
                        {adv_idex, adv_exmem, adv_memwb} = 3'b111;
                        flush_idex  = 1'b1;
                        dec_lduse_s = 1'b1;
                    end else if (istall_s) begin
                        {adv_ifid, adv_idex, adv_exmem, adv_memwb} = 4'b1111;
                        flush_ifid   = 1'b1;
                        dec_istall_s = 1'b1;
                    end else begin
                        {adv_ifid, adv_idex, adv_exmem, adv_memwb} = 4'b1111;
                        pc_load = 1'b1;
                    end
                end
                ST_REDIR_WAIT: begin
                    adv_ifid    = 1'b1;
                    flush_ifid  = 1'b1;
                    dec_flush_s = 1'b1;
                    {adv_idex, adv_exmem, adv_memwb} = {3{~dstall_s}};
                    if (imem_resp) begin
                        pc_load     = 1'b1;
                        pc_redirect = 1'b1;
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_REDIR_WAIT;
                    end
                end
                default: begin
                    state_nxt_s = ST_RUN;
                end
            endcase
        end
    end

    // Sequencer state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Consecutive-stall watchdog with saturating count and sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_r      <= {WD_W{1'b0}};
            mem_timeout_r <= 1'b0;
        end else if (dstall_s | istall_s) begin
            if (wd_cnt_r < WD_W'(TIMEOUT_CYCLES)) begin
                wd_cnt_r <= wd_cnt_r + WD_W'(1);
            end else begin
                wd_cnt_r <= wd_cnt_r;
            end
            if (wd_cnt_r >= WD_W'(TIMEOUT_CYCLES - 1)) begin
                mem_timeout_r <= 1'b1;
            end else begin
                mem_timeout_r <= mem_timeout_r;
            end
        end else begin
            wd_cnt_r      <= {WD_W{1'b0}};
            mem_timeout_r <= mem_timeout_r;
        end
    end

`ifdef PIPE_HAZARD_STATS_EN
    // Decision statistics; counters wrap naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_dstall <= {CNT_W{1'b0}};
            stat_istall <= {CNT_W{1'b0}};
            stat_lduse  <= {CNT_W{1'b0}};
            stat_flush  <= {CNT_W{1'b0}};
        end else begin
            stat_dstall <= stat_dstall + CNT_W'(dec_dstall_s);
            stat_istall <= stat_istall + CNT_W'(dec_istall_s);
            stat_lduse  <= stat_lduse + CNT_W'(dec_lduse_s);
            stat_flush  <= stat_flush + CNT_W'(dec_flush_s);
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TIMEOUT_CYCLES = 8).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       imem_resp, dmem_req, dmem_resp, br_taken;
    logic [2:0] id_src1, id_src2, ex_dest;
    logic       id_use_src1, id_use_src2, ex_load;
    logic       adv_ifid, adv_idex, adv_exmem, adv_memwb;
    logic       flush_ifid, flush_idex, flush_exmem;
    logic       pc_load, pc_redirect, target_latch, mem_timeout;
`ifdef PIPE_HAZARD_STATS_EN
    logic [31:0] stat_dstall, stat_istall, stat_lduse, stat_flush;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // {adv_ifid, adv_idex, adv_exmem, adv_memwb, flush_ifid, flush_idex, flush_exmem,
    //  pc_load, pc_redirect, target_latch}
    logic [9:0] ctl;
    assign ctl = {adv_ifid, adv_idex, adv_exmem, adv_memwb, flush_ifid, flush_idex,
                  flush_exmem, pc_load, pc_redirect, target_latch};

    localparam logic [9:0] C_IDLE    = 10'b0000000000;
    localparam logic [9:0] C_NORMAL  = 10'b1111000100;
    localparam logic [9:0] C_BR_RDY  = 10'b1111111110;
    localparam logic [9:0] C_BR_PEND = 10'b1111111011;
    localparam logic [9:0] C_LDUSE   = 10'b0111010000;
    localparam logic [9:0] C_ISTALL  = 10'b1111100000;
    localparam logic [9:0] C_RW_WAIT = 10'b1111100000;
    localparam logic [9:0] C_RW_DST  = 10'b1000100000;
    localparam logic [9:0] C_RW_DONE = 10'b1111100110;

    pipe_hazard_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .imem_resp(imem_resp), .dmem_req(dmem_req),
        .dmem_resp(dmem_resp), .br_taken(br_taken), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .ex_load(ex_load),
        .ex_dest(ex_dest), .adv_ifid(adv_ifid), .adv_idex(adv_idex), .adv_exmem(adv_exmem),
        .adv_memwb(adv_memwb), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .flush_exmem(flush_exmem), .pc_load(pc_load), .pc_redirect(pc_redirect),
        .target_latch(target_latch), .mem_timeout(mem_timeout)
`ifdef PIPE_HAZARD_STATS_EN
        , .stat_dstall(stat_dstall), .stat_istall(stat_istall),
        .stat_lduse(stat_lduse), .stat_flush(stat_flush)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0; br_taken = 1'b0;
        id_src1 = 3'd0; id_src2 = 3'd0; id_use_src1 = 1'b0; id_use_src2 = 1'b0;
        ex_load = 1'b0; ex_dest = 3'd0;
    endtask

    task automatic test_reset();
        @(negedge clk); #1;
        n_checks++;
        if (ctl !== C_IDLE) $display("FAIL reset_ctl: got %b want %b", ctl, C_IDLE);
        else n_pass++;
        n_checks++;
        if (mem_timeout !== 1'b0) $display("FAIL reset_timeout: got %b want 0", mem_timeout);
        else n_pass++;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_straight_line();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); idle_inputs(); #1;
            n_checks++;
            if (ctl !== C_NORMAL) $display("FAIL straight[%0d]: got %b want %b", i, ctl, C_NORMAL);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        // {use1, use2, src1, src2, dest, expected}
        logic [9:0] exp_v [4];
        logic [1:0] use_v [4];
        logic [2:0] s1_v [4];
        logic [2:0] s2_v [4];
        exp_v = '{C_LDUSE, C_LDUSE, C_NORMAL, C_NORMAL};
        use_v = '{2'b10, 2'b01, 2'b10, 2'b01};
        s1_v  = '{3'd3, 3'd5, 3'd2, 3'd3};
        s2_v  = '{3'd0, 3'd3, 3'd3, 3'd4};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle_inputs();
            ex_load = 1'b1; ex_dest = 3'd3;
            {id_use_src1, id_use_src2} = use_v[i];
            id_src1 = s1_v[i]; id_src2 = s2_v[i];
            #1;
            n_checks++;
            if (ctl !== exp_v[i]) $display("FAIL load_use[%0d]: got %b want %b", i, ctl, exp_v[i]);
            else n_pass++;
            @(negedge clk); idle_inputs(); #1;
            n_checks++;
            if (ctl !== C_NORMAL) $display("FAIL load_use_after[%0d]: got %b want %b", i, ctl, C_NORMAL);
            else n_pass++;
        end
    endtask

    task automatic test_dmiss();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); idle_inputs(); dmem_req = 1'b1;
            br_taken = (i == 2) ? 1'b1 : 1'b0;
            #1;
            n_checks++;
            if (ctl !== C_IDLE) $display("FAIL dmiss[%0d]: got %b want %b", i, ctl, C_IDLE);
            else n_pass++;
        end
        @(negedge clk); idle_inputs(); dmem_req = 1'b1; dmem_resp = 1'b1; #1;
        n_checks++;
        if (ctl !== C_NORMAL) $display("FAIL dmiss_resp: got %b want %b", ctl, C_NORMAL);
        else n_pass++;
        n_checks++;
        if (mem_timeout !== 1'b0) $display("FAIL dmiss_timeout: got %b want 0", mem_timeout);
        else n_pass++;
    endtask

    task automatic test_istall();
        @(negedge clk); idle_inputs(); imem_resp = 1'b0; #1;
        n_checks++;
        if (ctl !== C_ISTALL) $display("FAIL istall: got %b want %b", ctl, C_ISTALL);
        else n_pass++;
    endtask

    task automatic test_branch_ready();
        @(negedge clk); idle_inputs(); br_taken = 1'b1; #1;
        n_checks++;
        if (ctl !== C_BR_RDY) $display("FAIL br_ready: got %b want %b", ctl, C_BR_RDY);
        else n_pass++;
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (ctl !== C_NORMAL) $display("FAIL br_ready_after: got %b want %b", ctl, C_NORMAL);
        else n_pass++;
    endtask

    task automatic test_branch_pending();
        logic [9:0] exp_v [3];
        exp_v = '{C_RW_WAIT, C_RW_WAIT, C_RW_DST};
        @(negedge clk); idle_inputs(); br_taken = 1'b1; imem_resp = 1'b0; #1;
        n_checks++;
        if (ctl !== C_BR_PEND) $display("FAIL br_pend: got %b want %b", ctl, C_BR_PEND);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle_inputs(); imem_resp = 1'b0;
            dmem_req = (i == 2) ? 1'b1 : 1'b0;
            #1;
            n_checks++;
            if (ctl !== exp_v[i]) $display("FAIL redir_wait[%0d]: got %b want %b", i, ctl, exp_v[i]);
            else n_pass++;
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (ctl !== C_RW_DONE) $display("FAIL redir_done: got %b want %b", ctl, C_RW_DONE);
        else n_pass++;
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (ctl !== C_NORMAL) $display("FAIL redir_after: got %b want %b", ctl, C_NORMAL);
        else n_pass++;
    endtask

    task automatic test_timeout();
        // Seven stalls, a clean cycle, seven more: never eight consecutive
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); idle_inputs(); dmem_req = (i == 7) ? 1'b0 : 1'b1;
        end
        @(negedge clk); idle_inputs(); #1;
        n_checks++;
        if (mem_timeout !== 1'b0) $display("FAIL wd_not_consec: got %b want 0", mem_timeout);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); idle_inputs(); dmem_req = 1'b1; #1;
            n_checks++;
            if (mem_timeout !== 1'b0) $display("FAIL wd_early[%0d]: got %b want 0", i, mem_timeout);
            else n_pass++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); idle_inputs(); #1;
            n_checks++;
            if (mem_timeout !== 1'b1) $display("FAIL wd_sticky[%0d]: got %b want 1", i, mem_timeout);
            else n_pass++;
        end
        @(negedge clk); idle_inputs(); dmem_req = 1'b1;
        @(negedge clk); reset = 1'b1; #1;
        n_checks++;
        if ({ctl, mem_timeout} !== 11'b0) $display("FAIL reset_mid_stall: got %b want 0", {ctl, mem_timeout});
        else n_pass++;
        @(negedge clk); reset = 1'b0; idle_inputs(); #1;
        n_checks++;
        if ({ctl, mem_timeout} !== {C_NORMAL, 1'b0}) $display("FAIL post_reset: got %b want %b", {ctl, mem_timeout}, {C_NORMAL, 1'b0});
        else n_pass++;
    endtask

    task automatic test_reset_in_redir();
        @(negedge clk); idle_inputs(); br_taken = 1'b1; imem_resp = 1'b0;
        @(negedge clk); idle_inputs(); imem_resp = 1'b0; reset = 1'b1; #1;
        n_checks++;
        if (ctl !== C_IDLE) $display("FAIL reset_redir: got %b want %b", ctl, C_IDLE);
        else n_pass++;
        @(negedge clk); reset = 1'b0; idle_inputs(); #1;
        n_checks++;
        if (ctl !== C_NORMAL) $display("FAIL reset_redir_after: got %b want %b", ctl, C_NORMAL);
        else n_pass++;
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_straight_line();
        test_load_use();
        test_dmiss();
        test_istall();
        test_branch_ready();
        test_branch_pending();
        test_timeout();
        test_reset_in_redir();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
